// File: rtl/record_serializer_pkg.sv
// Shared types and helpers for the record serializer: FSM state encoding,
// word-count derivation and word selection by index and byte order.
package record_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } ser_state_e;

  // Widest record / word the generic selector can handle.
  localparam int MAX_REC_W = 1024;
  localparam int MAX_OUT_W = 256;

  function automatic int calc_words(input int record_w, input int out_w);
    int words;
    if (out_w > 0) begin
      words = record_w / out_w;
    end else begin
      words = 0;
    end
    return words;
  endfunction

  // Word 0 is the most significant word unless lsb_first is set.
  // Only the low out_w bits of the result are meaningful.
  function automatic logic [MAX_OUT_W-1:0] select_word(
    input logic [MAX_REC_W-1:0] rec,
    input int                   words,
    input int                   out_w,
    input int                   idx,
    input logic                 lsb_first
  );
    int                   pos;
    logic [MAX_REC_W-1:0] shifted;
    if (lsb_first) begin
      pos = idx;
    end else begin
      pos = words - 1 - idx;
    end
    shifted = rec >> (pos * out_w);
    return shifted[MAX_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/record_prefetch.sv
// Single-entry record prefetch register; pops the show-ahead FIFO with
// sample_req pulses that are never issued on two consecutive cycles.
module record_prefetch
  import record_serializer_pkg::*;
#(
  parameter int RECORD_W = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_rdy,
  input  logic [RECORD_W-1:0] sample,
  input  logic                take,
  output logic                sample_req,
  output logic                pf_valid,
  output logic [RECORD_W-1:0] pf_data,
  output logic                pf_valid_nxt
);

  logic                req_r;
  logic                valid_r;
  logic [RECORD_W-1:0] data_r;
  logic                fill_s;
  logic                valid_nxt_s;
  logic [RECORD_W-1:0] data_nxt_s;

  // The FIFO head is stale the cycle after a pop, so skip that cycle.
  assign fill_s = sample_rdy && !req_r && (!valid_r || take);

  // Next prefetch contents: refill wins over a plain drain.
  always_comb begin
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;
    if (fill_s) begin
      valid_nxt_s = 1'b1;
      data_nxt_s  = sample;
    end else if (take) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // Prefetch and pop-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      req_r   <= fill_s;
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign sample_req   = req_r;
  assign pf_valid     = valid_r;
  assign pf_data      = data_r;
  assign pf_valid_nxt = valid_nxt_s;

endmodule

// File: rtl/record_serializer.sv
// Serializes RECORD_W-bit timetag records into OUT_W-bit host words with a
// zero-bubble prefetch. Define SERIALIZER_CHECKSUM_EN to append an XOR word.
module record_serializer
  import record_serializer_pkg::*;
#(
  parameter int RECORD_W  = 48,
  parameter int OUT_W     = 8,
  parameter int LSB_FIRST = 0,
  parameter int COUNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_rdy,
  input  logic [RECORD_W-1:0] sample,
  output logic                sample_req,
  output logic                data_rdy,
  output logic [OUT_W-1:0]    data,
  input  logic                data_ack,
  output logic                busy,
  output logic [COUNT_W-1:0]  rec_count
);

  localparam int WORDS = calc_words(RECORD_W, OUT_W);
  localparam int IDX_W = $clog2(WORDS + 1);

  generate
    if ((OUT_W < 1) || (RECORD_W % OUT_W != 0) || (WORDS < 1) ||
        (RECORD_W > MAX_REC_W) || (OUT_W > MAX_OUT_W)) begin : g_bad_cfg
      $error("record_serializer: RECORD_W must be a non-zero multiple of OUT_W");
    end
  endgenerate

  ser_state_e          state_r;
  ser_state_e          state_nxt_s;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic [RECORD_W-1:0] shreg_r;
  logic [RECORD_W-1:0] shreg_nxt_s;
  logic [OUT_W-1:0]    data_r;
  logic [OUT_W-1:0]    data_nxt_s;
  logic                data_rdy_r;
  logic                data_rdy_nxt_s;
  logic [COUNT_W-1:0]  rec_count_r;
  logic [COUNT_W-1:0]  rec_count_nxt_s;
  logic                busy_r;
  logic                take_s;
  logic                start_s;
  logic                frame_done_s;
  logic                xfer_s;
  logic                last_s;
  logic                pf_valid_s;
  logic                pf_valid_nxt_s;
  logic [RECORD_W-1:0] pf_data_s;

  function automatic logic [OUT_W-1:0] word_at(input logic [RECORD_W-1:0] rec,
                                               input int idx);
    logic [MAX_OUT_W-1:0] w;
    w = select_word(MAX_REC_W'(rec), WORDS, OUT_W, idx, LSB_FIRST != 0);
    return w[OUT_W-1:0];
  endfunction

`ifdef SERIALIZER_CHECKSUM_EN
  function automatic logic [OUT_W-1:0] xor_fold(input logic [RECORD_W-1:0] rec);
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WORDS; i++) begin
      acc = acc ^ rec[i*OUT_W +: OUT_W];
    end
    return acc;
  endfunction
`endif

  record_prefetch #(
    .RECORD_W (RECORD_W)
  ) u_prefetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_rdy   (sample_rdy),
    .sample       (sample),
    .take         (take_s),
    .sample_req   (sample_req),
    .pf_valid     (pf_valid_s),
    .pf_data      (pf_data_s),
    .pf_valid_nxt (pf_valid_nxt_s)
  );

  assign xfer_s = data_rdy_r && data_ack;
  assign last_s = (idx_r == IDX_W'(WORDS - 1));

  // Next-state and output decode; outputs are registered one level down.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx_r;
    shreg_nxt_s     = shreg_r;
    data_nxt_s      = data_r;
    data_rdy_nxt_s  = data_rdy_r;
    rec_count_nxt_s = rec_count_r;
    take_s          = 1'b0;
    start_s         = 1'b0;
    frame_done_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (pf_valid_s) begin
          start_s = 1'b1;
        end else begin
          data_rdy_nxt_s = 1'b0;
        end
      end
      ST_SEND: begin
        if (xfer_s && last_s) begin
`ifdef SERIALIZER_CHECKSUM_EN
          state_nxt_s = ST_CSUM;
          data_nxt_s  = xor_fold(shreg_r);
`else
          frame_done_s = 1'b1;
`endif
        end else if (xfer_s) begin
          idx_nxt_s  = idx_r + IDX_W'(1);
          data_nxt_s = word_at(shreg_r, int'(idx_r) + 1);
        end else begin
          data_nxt_s = data_r;
        end
      end
      ST_CSUM: begin
`ifdef SERIALIZER_CHECKSUM_EN
        if (xfer_s) begin
          frame_done_s = 1'b1;
        end else begin
          data_nxt_s = data_r;
        end
`else
        state_nxt_s    = ST_IDLE;
        data_rdy_nxt_s = 1'b0;
`endif
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        data_rdy_nxt_s = 1'b0;
      end
    endcase

    // End of frame: count it, then reload back-to-back if a record waits.
    if (frame_done_s) begin
      rec_count_nxt_s = rec_count_r + COUNT_W'(1);
      if (pf_valid_s) begin
        start_s = 1'b1;
      end else begin
        state_nxt_s    = ST_IDLE;
        data_rdy_nxt_s = 1'b0;
      end
    end else begin
      rec_count_nxt_s = rec_count_r;
    end

    if (start_s) begin
      take_s         = 1'b1;
      shreg_nxt_s    = pf_data_s;
      idx_nxt_s      = '0;
      data_nxt_s     = word_at(pf_data_s, 0);
      data_rdy_nxt_s = 1'b1;
      state_nxt_s    = ST_SEND;
    end else begin
      take_s = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      shreg_r     <= '0;
      data_r      <= '0;
      data_rdy_r  <= 1'b0;
      rec_count_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      shreg_r     <= shreg_nxt_s;
      data_r      <= data_nxt_s;
      data_rdy_r  <= data_rdy_nxt_s;
      rec_count_r <= rec_count_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE) || pf_valid_nxt_s;
    end
  end

  assign data_rdy  = data_rdy_r;
  assign data      = data_r;
  assign rec_count = rec_count_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_record_serializer.sv
// Self-checking bench for record_serializer: MSB-first and LSB-first instances
// share one modelled show-ahead FIFO and are checked against a word scoreboard.
module tb_record_serializer;

  localparam int RW    = 48;
  localparam int OW    = 8;
  localparam int CW    = 32;
  localparam int WORDS = RW / OW;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int FRAME = WORDS + 1;
`else
  localparam int FRAME = WORDS;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_rdy = 1'b0;
  logic [RW-1:0] sample = '0;
  logic          data_ack = 1'b0;

  logic          sample_req_m, data_rdy_m, busy_m;
  logic [OW-1:0] data_m;
  logic [CW-1:0] rec_count_m;
  logic          sample_req_l, data_rdy_l, busy_l;
  logic [OW-1:0] data_l;
  logic [CW-1:0] rec_count_l;

  always #5 clk = ~clk;

  record_serializer #(.RECORD_W(RW), .OUT_W(OW), .LSB_FIRST(0), .COUNT_W(CW)) dut_msb (
    .clk(clk), .rst_n(rst_n), .sample_rdy(sample_rdy), .sample(sample),
    .sample_req(sample_req_m), .data_rdy(data_rdy_m), .data(data_m),
    .data_ack(data_ack), .busy(busy_m), .rec_count(rec_count_m));

  record_serializer #(.RECORD_W(RW), .OUT_W(OW), .LSB_FIRST(1), .COUNT_W(CW)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .sample_rdy(sample_rdy), .sample(sample),
    .sample_req(sample_req_l), .data_rdy(data_rdy_l), .data(data_l),
    .data_ack(data_ack), .busy(busy_l), .rec_count(rec_count_l));

  typedef struct {
    logic [OW-1:0] m;
    logic [OW-1:0] l;
  } word_t;

  typedef struct {
    logic [RW-1:0] rec;
    logic [RW-1:0] msb_seq;
    logic [RW-1:0] lsb_seq;
    logic [OW-1:0] csum;
  } vec_t;

  word_t         exp_q[$];
  logic [RW-1:0] fifo_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            xfers = 0;
  int            req_pulses = 0;
  int            adj_req = 0;
  bit            prev_req = 1'b0;
  bit            ack_rand = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void refresh_fifo();
    sample_rdy = (fifo_q.size() != 0);
    sample     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  // Reference model: record split into words by plain shifting, plus XOR word.
  function automatic void push_record(logic [RW-1:0] rec);
    word_t         w;
    logic [OW-1:0] cs;
    logic [RW-1:0] t;
    cs = '0;
    fifo_q.push_back(rec);
    for (int k = 0; k < WORDS; k++) begin
      t   = rec >> (OW * (WORDS - 1 - k));
      w.m = t[OW-1:0];
      t   = rec >> (OW * k);
      w.l = t[OW-1:0];
      cs  = cs ^ w.m;
      exp_q.push_back(w);
    end
`ifdef SERIALIZER_CHECKSUM_EN
    w.m = cs;
    w.l = cs;
    exp_q.push_back(w);
`endif
    refresh_fifo();
  endfunction

  task automatic step();
    logic          rdy0, ack0, req0;
    logic [OW-1:0] dm0, dl0;
    word_t         e;
    rdy0 = data_rdy_m; ack0 = data_ack; req0 = sample_req_m;
    dm0  = data_m;     dl0  = data_l;
    if (req0) begin
      req_pulses++;
      if (prev_req) adj_req++;
    end
    prev_req = req0;
    if (rdy0 && ack0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_extra_word: got %0h expected none", dm0);
      end else begin
        e = exp_q.pop_front();
        check("sb_msb", 64'(dm0), 64'(e.m));
        check("sb_lsb", 64'(dl0), 64'(e.l));
      end
      xfers++;
    end
    @(posedge clk);
    #1;
    if (req0 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh_fifo();
    if (rdy0 && !ack0) begin
      check("hold_rdy", 64'(data_rdy_m), 64'(1));
      check("hold_data_msb", 64'(data_m), 64'(dm0));
      check("hold_data_lsb", 64'(data_l), 64'(dl0));
    end
    if (rdy0 && ack0 && (xfers % FRAME == 0)) begin
      check("rec_count", 64'(rec_count_m), 64'(xfers / FRAME));
      check("rec_count_lsb", 64'(rec_count_l), 64'(xfers / FRAME));
    end
    data_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_rdy(string name);
    for (int c = 0; c < 12 && !data_rdy_m; c++) step();
    check(name, 64'(data_rdy_m), 64'(1));
  endtask

  vec_t          tbl[4];
  logic [RW-1:0] t;
  logic [OW-1:0] exp_m, exp_l;
  int            req_before, base, gaps, pushed, ever_rdy, x0;

  initial begin
    tbl[0] = '{48'h0123456789AB, 48'h0123456789AB, 48'hAB8967452301, 8'h22};
    tbl[1] = '{48'hFFFF00000000, 48'hFFFF00000000, 48'h00000000FFFF, 8'h00};
    tbl[2] = '{48'hA5A5A5A5A5A5, 48'hA5A5A5A5A5A5, 48'hA5A5A5A5A5A5, 8'h00};
    tbl[3] = '{48'h000000000001, 48'h000000000001, 48'h010000000000, 8'h01};

    repeat (3) @(posedge clk);
    #1;
    check("reset_data_rdy", 64'(data_rdy_m), 64'(0));
    check("reset_data", 64'(data_m), 64'(0));
    check("reset_busy", 64'(busy_m), 64'(0));
    check("reset_sample_req", 64'(sample_req_m), 64'(0));
    check("reset_rec_count", 64'(rec_count_m), 64'(0));
    rst_n    = 1'b1;
    data_ack = 1'b1;

    // Table: one record at a time from idle, data_ack tied high.
    for (int i = 0; i < 4; i++) begin
      req_before = req_pulses;
      push_record(tbl[i].rec);
      if (i == 0) begin
        step();
        check("latency_cycle1", 64'(data_rdy_m), 64'(0));
        step();
        check("latency_cycle2", 64'(data_rdy_m), 64'(1));
      end else begin
        wait_rdy("tbl_start");
      end
      for (int w = 0; w < FRAME; w++) begin
        if (w < WORDS) begin
          t = tbl[i].msb_seq >> (OW * (WORDS - 1 - w)); exp_m = t[OW-1:0];
          t = tbl[i].lsb_seq >> (OW * (WORDS - 1 - w)); exp_l = t[OW-1:0];
        end else begin
          exp_m = tbl[i].csum; exp_l = tbl[i].csum;
        end
        check("tbl_rdy", 64'(data_rdy_m), 64'(1));
        check("tbl_word_msb", 64'(data_m), 64'(exp_m));
        check("tbl_word_lsb", 64'(data_l), 64'(exp_l));
        step();
      end
      check("tbl_rec_count", 64'(rec_count_m), 64'(i + 1));
      check("tbl_one_req", 64'(req_pulses - req_before), 64'(1));
      check("tbl_idle_busy", 64'(busy_m), 64'(0));
      check("tbl_idle_rdy", 64'(data_rdy_m), 64'(0));
    end

    // Three queued records must stream without a gap.
    base = int'(rec_count_m);
    push_record(48'h111111111111);
    push_record(48'h2233445566AA);
    push_record(48'hDEADBEEFCAFE);
    wait_rdy("burst_start");
    gaps = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (!data_rdy_m) gaps++;
      step();
    end
    check("burst_gaps", 64'(gaps), 64'(0));
    check("burst_rec_count", 64'(rec_count_m), 64'(base + 3));
    check("burst_req_spacing", 64'(adj_req), 64'(0));

    // Random arrivals with random back-pressure.
    ack_rand = 1'b1;
    base     = int'(rec_count_m);
    pushed   = 0;
    for (int c = 0; c < 5000; c++) begin
      if (pushed < 20 && $urandom_range(0, 3) == 0) begin
        push_record({$urandom(), 16'($urandom())});
        pushed++;
      end
      if (pushed == 20 && exp_q.size() == 0 && fifo_q.size() == 0 && !busy_m) break;
      step();
    end
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_rec_count", 64'(rec_count_m), 64'(base + 20));
    check("rand_req_spacing", 64'(adj_req), 64'(0));

    // Reset after the third word of a record, with a second record prefetched.
    ack_rand = 1'b0;
    data_ack = 1'b1;
    step();
    push_record(48'hCAFEF00D1234);
    push_record(48'h0F0F0F0F0F0F);
    x0 = xfers;
    for (int c = 0; c < 20 && (xfers - x0) < 3; c++) step();
    check("rst_words_before", 64'(xfers - x0), 64'(3));
    rst_n = 1'b0;
    #1;
    check("rst_data_rdy", 64'(data_rdy_m), 64'(0));
    check("rst_data", 64'(data_m), 64'(0));
    check("rst_rec_count", 64'(rec_count_m), 64'(0));
    check("rst_busy", 64'(busy_m), 64'(0));
    check("rst_sample_req", 64'(sample_req_m), 64'(0));
    fifo_q.delete();
    exp_q.delete();
    refresh_fifo();
    xfers    = 0;
    prev_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ever_rdy = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (data_rdy_m || data_rdy_l) ever_rdy++;
    end
    check("post_rst_rdy", 64'(ever_rdy), 64'(0));
    check("post_rst_rec_count", 64'(rec_count_m), 64'(0));
    check("post_rst_busy", 64'(busy_m), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/record_serializer.md
Name: record_serializer

Overview:
- Parametrised successor to the fixed 48-bit-to-byte sample multiplexer.
- Pops RECORD_W-bit timetag records from a show-ahead record FIFO and emits them as OUT_W-bit words on the host data handshake.
- Byte order is selectable.
- A one-record prefetch register gives back-to-back records without bubbles.
- Sits between the record FIFO read side and the FX2 data path, all in the host clock domain.

Parameters:
- RECORD_W, 48, record width in bits; must be an integer multiple of OUT_W.
- OUT_W, 8, output word width in bits.
- LSB_FIRST, 0, 0 = most-significant word first; 1 = least-significant word first.
- COUNT_W, 32, width of the completed-record counter.

Ports:
- clk  in  1  host clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_rdy  in  1  FIFO non-empty; sample is valid.
- sample  in  RECORD_W  show-ahead FIFO head.
- sample_req  out  1  one-cycle pop pulse.
- data_rdy  out  1  output word valid.
- data  out  OUT_W  output word.
- data_ack  in  1  consumer accepts word.
- busy  out  1  a record is in flight or prefetched.
- rec_count  out  COUNT_W  number of records fully transmitted.

Behaviour:
- WORDS = RECORD_W/OUT_W. Elaboration error if RECORD_W % OUT_W != 0 or WORDS < 1.
- Reset values (asynchronous, on rst_n low): sample_req=0, data_rdy=0, data=0, busy=0, rec_count=0, prefetch valid=0, state=IDLE.
- Reset mid-record discards the in-flight record and the prefetched record; no partial record resumes.
- Prefetch:
  - If prefetch is empty, sample_rdy=1, and no sample_req was issued in the previous cycle, then pulse sample_req and latch sample into prefetch.
  - sample_req is never high on two consecutive cycles; the FIFO updates its head the cycle after a pop.
- Transfer rule: a word transfers on a rising edge where data_rdy && data_ack. data must hold stable while data_rdy && !data_ack.
- FSM:
  - IDLE: data_rdy=0. When prefetch is valid, move it into the shift register, clear prefetch, set word index to 0, go to SEND.
  - SEND: data_rdy=1. data is word[idx]; with LSB_FIRST=0, word 0 is bits RECORD_W-1 down to RECORD_W-OUT_W. On transfer, idx++.
  - On transfer of the last word:
    - rec_count increments and wraps at 2^COUNT_W.
    - If prefetch is valid that same cycle, load it and stay in SEND with data_rdy held high (zero-bubble).
    - Otherwise go to IDLE.
- Prefetch load and shift-register load may occur in the same cycle. The shift register takes the old prefetch contents; prefetch takes sample.
- Latency from sample_rdy rising (idle, empty prefetch) to data_rdy high: 2 cycles.
- busy = (state != IDLE) || prefetch valid.
- data_ack while data_rdy=0 is ignored.

Optional Feature:
- Macro: SERIALIZER_CHECKSUM_EN.
- Defined:
  - After the last data word of each record, a CSUM state emits one extra OUT_W word equal to the XOR of all WORDS words of that record.
  - CSUM uses the same handshake and holds data stable until acked.
  - rec_count increments when the checksum word transfers.
  - The zero-bubble reload applies after CSUM.
- Undefined: no CSUM state; framing is exactly WORDS words per record.

Decomposition:
- Shared package: state encoding (IDLE/SEND/CSUM), the WORDS derivation function, and the word-select function by index and LSB_FIRST.
- One sub-module, record_prefetch: the single-entry prefetch register with the sample_req spacing rule.
- The FSM and word mux stay in record_serializer.

Test Plan:
- Default params, single record 48'h0123456789AB, data_ack tied high -> data sequence 01,23,45,67,89,AB on 6 consecutive cycles; rec_count=1; exactly one sample_req pulse.
- LSB_FIRST=1, same record -> AB,89,67,45,23,01.
- Three records queued, data_ack tied high -> 18 consecutive words with data_rdy never low between records; sample_req never asserted on adjacent cycles; rec_count=3.
- data_ack toggled pseudo-randomly -> every word held stable until acked; no word lost or duplicated; scoreboard matches the record stream.
- rst_n asserted after the 3rd word of a record -> outputs zero immediately; after release with empty FIFO, data_rdy stays 0 and rec_count=0.
- SERIALIZER_CHECKSUM_EN defined, record 48'h0123456789AB -> 01,23,45,67,89,AB,22; rec_count increments after the 7th word.
